// File: rtl/toggle_counter_pkg.sv
// Shared constants for the toggle counter slice.
//   DIR_UP / DIR_DOWN   : values of the 'up' direction input
//   DEFAULT_WIDTH       : default counter width in bits
//   DEFAULT_MODULUS     : default count range (0..MODULUS-1)
package toggle_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 16;

endpackage

// File: rtl/toggle_counter_if.sv
// Control/status bundle of the toggle counter.
//   enable, up, load, load_value : requests into the counter
//   Q, Qnot, tc, wrapped         : counter state and flags out
// Modports: master drives the requests, slave is the counter itself.
interface toggle_counter_if
  import toggle_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qnot;
  logic             tc;
  logic             wrapped;

  modport master (
    output enable, up, load, load_value,
    input  Q, Qnot, tc, wrapped
  );

  modport slave (
    input  enable, up, load, load_value,
    output Q, Qnot, tc, wrapped
  );

endinterface

// File: rtl/toggle_stage.sv
// One bit of the toggle counter.
// Ports:
//   clock    : rising-edge clock
//   clear    : synchronous active-high clear (q=0, qn=1)
//   load     : synchronous load of load_bit
//   load_bit : value taken on load
//   toggle   : invert the stored bit this edge
//   q, qn    : stored bit and its complement, both registered
// Priority: clear > load > toggle > hold.
module toggle_stage (
  input  logic clock,
  input  logic clear,
  input  logic load,
  input  logic load_bit,
  input  logic toggle,
  output logic q,
  output logic qn
);

  // Declaration initialisers give the power-up state before the first clear.
  logic q_r  = 1'b0;
  logic qn_r = 1'b1;

  // qn is its own flop (not an inverter on q) so both outputs change on
  // the same edge with no combinational skew between them.
  always_ff @(posedge clock) begin
    if (clear) begin
      q_r  <= 1'b0;
      qn_r <= 1'b1;
    end else if (load) begin
      q_r  <= load_bit;
      qn_r <= ~load_bit;
    end else if (toggle) begin
      q_r  <= ~q_r;
      qn_r <= q_r;
    end
  end

  assign q  = q_r;
  assign qn = qn_r;

endmodule

// File: rtl/toggle_counter.sv
// Up/down modulo counter built from WIDTH toggle stages.
// Ports:
//   clock : rising-edge clock
//   clear : synchronous active-high clear
//   bus   : toggle_counter_if.slave (enable, up, load, load_value in;
//           Q, Qnot, tc, wrapped out)
// Parameters: WIDTH (1..16), MODULUS (2..2**WIDTH).
// Build option: define TOGGLE_COUNTER_SAT_EN to hold Q at the terminal
// value instead of wrapping; tc and wrapped behave the same either way.
module toggle_counter
  import toggle_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic               clock,
  input  logic               clear,
  toggle_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qnot;
  logic [WIDTH-1:0] load_bits;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] toggle_bits;
  logic             at_term;
  logic             tc_int;
  logic             wrapped_r = 1'b0;

  always_comb begin
    load_bits   = '0;
    step_val    = q;
    toggle_bits = '0;
    at_term     = 1'b0;
    tc_int      = 1'b0;

    // Out-of-range loads clamp so Q can never leave 0..MODULUS-1.
    if (32'(bus.load_value) >= 32'(MODULUS))
      load_bits = TOP_VAL;
    else
      load_bits = bus.load_value;

    at_term = (bus.up == DIR_UP) ? (q == TOP_VAL) : (q == '0);

    if (at_term) begin
`ifdef TOGGLE_COUNTER_SAT_EN
      step_val = q;
`else
      step_val = (bus.up == DIR_UP) ? '0 : TOP_VAL;
`endif
    end else begin
      step_val = (bus.up == DIR_UP) ? q + 1'b1 : q - 1'b1;
    end

    // Each stage only knows how to flip, so the step becomes a flip mask.
    if (bus.enable)
      toggle_bits = q ^ step_val;

    tc_int = bus.enable & ~bus.load & ~clear & at_term;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    toggle_stage u_stage (
      .clock    (clock),
      .clear    (clear),
      .load     (bus.load),
      .load_bit (load_bits[i]),
      .toggle   (toggle_bits[i]),
      .q        (q[i]),
      .qn       (qnot[i])
    );
  end

  always_ff @(posedge clock) begin
    if (clear)
      wrapped_r <= 1'b0;
    else if (tc_int)
      wrapped_r <= 1'b1;
  end

  assign bus.Q       = q;
  assign bus.Qnot    = qnot;
  assign bus.tc      = tc_int;
  assign bus.wrapped = wrapped_r;

endmodule

// File: doc/toggle_counter.md
TOGGLE_COUNTER -- requirements
Module: toggle_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter bit width (legal 1..16).
REQ-002 SHALL have parameter MODULUS, default 16, count range 0..MODULUS-1 (legal 2..2**WIDTH).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge only.
REQ-004 SHALL have port clear  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port enable  input  1  count step request for the current cycle.
REQ-006 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 SHALL have port load_value  input  WIDTH  value captured on load.
REQ-009 SHALL have port Q  output  WIDTH  registered count.
REQ-010 SHALL have port Qnot  output  WIDTH  bitwise complement of Q, registered, never skewed from Q.
REQ-011 SHALL have port tc  output  1  terminal-count flag, combinational from registered state and inputs.
REQ-012 SHALL have port wrapped  output  1  sticky flag, registered.

Function
REQ-013 Priority per edge SHALL be clear > load > enable > hold.
REQ-014 load SHALL set Q to load_value next edge; load_value >= MODULUS SHALL clamp to MODULUS-1.
REQ-015 enable with up=1 SHALL set Q to Q+1; at Q=MODULUS-1 SHALL set Q to 0.
REQ-016 enable with up=0 SHALL set Q to Q-1; at Q=0 SHALL set Q to MODULUS-1.
REQ-017 enable=0 and load=0 SHALL hold Q, Qnot, wrapped.
REQ-018 Latency from input to Q change SHALL be exactly one clock edge.
REQ-019 tc SHALL be 1 iff enable=1, load=0, clear=0 and Q is at the terminal value for the current direction (MODULUS-1 up, 0 down).
REQ-020 wrapped SHALL set to 1 on any edge where tc=1 and remain 1 until clear.
REQ-021 load SHALL NOT affect wrapped; load asserted with enable SHALL suppress counting and tc.
REQ-022 Direction change mid-count SHALL take effect on the same edge as the enable it accompanies.
REQ-023 Q SHALL never hold a value >= MODULUS.
REQ-024 Qnot SHALL equal ~Q at every clock edge after reset.

Reset
REQ-025 clear=1 at rising edge SHALL set Q=0, Qnot=all ones, wrapped=0, regardless of load/enable.
REQ-026 clear between edges SHALL have no effect; tc SHALL be forced 0 while clear=1.
REQ-027 Power-up value before first clear SHALL be Q=0, Qnot=all ones, wrapped=0.

Configuration
REQ-028 Macro TOGGLE_COUNTER_SAT_EN defined SHALL select saturating mode: at terminal value enable holds Q, tc still asserts, wrapped still sets.
REQ-029 Macro TOGGLE_COUNTER_SAT_EN undefined SHALL select wrap mode per REQ-015/016.

Structure
REQ-030 Shared package toggle_counter_pkg SHALL hold direction constants (DIR_UP=1, DIR_DOWN=0) and default WIDTH/MODULUS constants.
REQ-031 Sub-module toggle_stage SHALL implement one bit: synchronous clear, load, toggle enable, Q and Qnot outputs; toggle_counter SHALL instantiate WIDTH of them with per-bit toggle and wrap/clamp logic at top level.

Verification (WIDTH=4, MODULUS=10)
REQ-032 clear 1 cycle, then enable=1 up=1 for 12 cycles -> Q 0..9,0,1,2; tc=1 in cycle Q=9; wrapped=1 from cycle after; Qnot=~Q throughout.
REQ-033 clear, enable=1 up=0 -> Q 9,8,...; tc=1 at Q=0 before first step; with TOGGLE_COUNTER_SAT_EN Q stays 0, tc=1 each cycle.
REQ-034 load=1 load_value=13 -> Q=9 next edge; load=1 enable=1 load_value=4 at Q=9 -> Q=4, tc=0, wrapped unchanged.
REQ-035 clear=1 with load=1 enable=1 at Q=7 wrapped=1 -> Q=0, Qnot=4'hF, wrapped=0, tc=0.
REQ-036 enable=0 for 5 cycles at Q=6 with up toggling -> Q stays 6, tc=0.
